// File: rtl/niosii_niosii_oci_dct_packer_pkg.sv
// ============================================================================
// Module : niosii_NIOSII_oci_dct_pkg
// Brief  : Shared widths, FSM state encoding and code-insert helper for the
//          OCI debug-trace packer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package niosii_NIOSII_oci_dct_pkg;

    localparam int CODE_W      = 2;
    localparam int FRAME_CODES = 15;
    localparam int CNT_W       = 4;
    localparam int DCT_BUF_W   = CODE_W * FRAME_CODES;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_CODES);

    typedef logic [1:0] dct_state_t;
    localparam dct_state_t ST_RUN    = 2'd0;
    localparam dct_state_t ST_DRAIN  = 2'd1;
    localparam dct_state_t ST_ENDING = 2'd2;
    localparam dct_state_t ST_ENDED  = 2'd3;

    // Returns buf_in with code written into slot pos; slots beyond the frame are ignored.
    function automatic logic [DCT_BUF_W-1:0] put_code(
        input logic [DCT_BUF_W-1:0] buf_in,
        input logic [CNT_W-1:0]     pos,
        input logic [CODE_W-1:0]    code
    );
        logic [DCT_BUF_W-1:0] r;
        r = buf_in;
        for (int k = 0; k < FRAME_CODES; k++) begin
            if (pos == CNT_W'(k)) begin
                r[k*CODE_W +: CODE_W] = code;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/niosii_niosii_oci_dct_packer.sv
// ============================================================================
// Module : niosii_niosii_oci_dct_packer
// Brief  : Packs 2-bit trace codes into 15-code frames and sequences end-of-test.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module niosii_niosii_oci_dct_packer
    import niosii_NIOSII_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    in_code,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 end_req,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]     dct_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 test_ending,
    output logic                 test_has_ended
);

    logic [DCT_BUF_W-1:0] r_acc;
    logic [CNT_W-1:0]     r_acc_cnt;
    logic                 r_flush_pend;
    logic                 r_live;
    dct_state_t           r_state;

    logic                 w_out_free;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_flush_req;
    logic                 w_xfer;
    logic                 w_pend;
    logic [DCT_BUF_W-1:0] w_nxt_acc;
    logic [CNT_W-1:0]     w_nxt_cnt;
    logic [DCT_BUF_W-1:0] w_rem_acc;
    logic [CNT_W-1:0]     w_rem_cnt;

    assign w_out_free  = !out_valid || out_ready;
    assign w_full      = (r_acc_cnt == FULL_CNT);
    assign in_ready    = r_live && (r_state == ST_RUN) && (!w_full || w_out_free);
    assign w_accept    = in_valid && in_ready;
    assign w_flush_req = flush || r_flush_pend || (r_state == ST_DRAIN);

    always_comb begin
        w_nxt_acc = r_acc;
        w_nxt_cnt = r_acc_cnt;
        w_xfer    = 1'b0;
        w_rem_acc = r_acc;
        w_rem_cnt = r_acc_cnt;
        w_pend    = 1'b0;
        if (w_full) begin
            // A full accumulator can only move out; a code accepted now starts the next frame.
            w_xfer = w_out_free;
            if (w_xfer) begin
                w_rem_acc = w_accept ? put_code('0, '0, in_code) : '0;
                w_rem_cnt = {{(CNT_W-1){1'b0}}, w_accept};
                w_pend    = flush && w_accept;
            end else begin
                w_pend    = flush || r_flush_pend;
            end
        end else begin
            if (w_accept) begin
                w_nxt_acc = put_code(r_acc, r_acc_cnt, in_code);
                w_nxt_cnt = r_acc_cnt + 1'b1;
            end
            w_xfer = w_out_free &&
                     ((w_nxt_cnt == FULL_CNT) || (w_flush_req && (w_nxt_cnt != '0)));
            w_rem_acc = w_xfer ? '0 : w_nxt_acc;
            w_rem_cnt = w_xfer ? '0 : w_nxt_cnt;
            w_pend    = (flush || r_flush_pend) && !w_xfer && (w_nxt_cnt != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc          <= '0;
            r_acc_cnt      <= '0;
            r_flush_pend   <= 1'b0;
            r_live         <= 1'b0;
            r_state        <= ST_RUN;
            dct_buffer     <= '0;
            dct_count      <= '0;
            out_valid      <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_acc        <= w_rem_acc;
            r_acc_cnt    <= w_rem_cnt;
            r_flush_pend <= w_pend;
            test_ending  <= 1'b0;

            if (w_xfer) begin
                dct_buffer <= w_nxt_acc;
                dct_count  <= w_nxt_cnt;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (end_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((r_acc_cnt == '0) && !out_valid) begin
                        r_state     <= ST_ENDING;
                        test_ending <= 1'b1;
                    end
                end
                ST_ENDING: begin
                    r_state        <= ST_ENDED;
                    test_has_ended <= 1'b1;
                end
                default: begin
                    r_state <= ST_ENDED;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_niosii_niosii_oci_dct_packer.sv
// ============================================================================
// Module : tb_niosii_niosii_oci_dct_packer
// Brief  : Directed and scoreboarded self-checking bench for the DCT packer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_niosii_niosii_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        in_ready;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic        out_ready;
    logic        test_ending;
    logic        test_has_ended;

    int total = 0;
    int bad   = 0;
    logic [1:0] q[$];

    niosii_niosii_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .in_ready       (in_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        in_valid = 1'b1;
        in_code  = code;
        tick();
    endtask

    task automatic check_frame();
        logic [29:0] e;
        int n;
        e = '0;
        n = int'(dct_count);
        chk("rnd_count_ok", 32'(n >= 1 && n <= 15 && n <= q.size()), 32'd1);
        if (n >= 1 && n <= 15 && n <= q.size()) begin
            for (int k = 0; k < n; k++) e[2*k +: 2] = q.pop_front();
            chk("rnd_frame", 32'(dct_buffer), 32'(e));
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_code = 2'd0;
        flush = 1'b0; end_req = 1'b0; out_ready = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_buffer", 32'(dct_buffer), 0);
        chk("rst_count", 32'(dct_count), 0);
        chk("rst_flags", 32'({test_ending, test_has_ended}), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // full frame 0,1,2,3,... with free output
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) send(2'(k % 4));
        chk("f1_not_early", 32'(out_valid), 0);
        send(2'd2);
        in_valid = 1'b0;
        chk("f1_valid", 32'(out_valid), 1);
        chk("f1_count", 32'(dct_count), 15);
        chk("f1_buffer", 32'(dct_buffer), 32'h24E4_E4E4);
        tick();
        chk("f1_one_cycle", 32'(out_valid), 0);

        // stalled output: frame A out, frame B fills acc, 16th waits
        out_ready = 1'b0;
        for (int k = 0; k < 15; k++) send(2'((k + 1) % 4));
        chk("fa_valid", 32'(out_valid), 1);
        chk("fa_buffer", 32'(dct_buffer), 32'h3939_3939);
        for (int k = 0; k < 15; k++) send(2'(3 - (k % 4)));
        in_valid = 1'b1; in_code = 2'd2;
        #1;
        chk("full_in_ready", 32'(in_ready), 0);
        tick(); tick();
        chk("stall_hold_valid", 32'(out_valid), 1);
        chk("stall_hold_buffer", 32'(dct_buffer), 32'h3939_3939);
        chk("stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("fb_valid", 32'(out_valid), 1);
        chk("fb_count", 32'(dct_count), 15);
        chk("fb_buffer", 32'(dct_buffer), 32'h1B1B_1B1B);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f16_count", 32'(dct_count), 1);
        chk("f16_buffer", 32'(dct_buffer), 32'h2);
        tick();
        chk("f16_done", 32'(out_valid), 0);

        // partial frame with flush on the last accept, then flush on empty
        send(2'd3); send(2'd2);
        flush = 1'b1;
        send(2'd1);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 1);
        chk("fl_count", 32'(dct_count), 3);
        chk("fl_buffer", 32'(dct_buffer), 32'h1B);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush_a", 32'(out_valid), 0);
        tick();
        chk("empty_flush_b", 32'(out_valid), 0);

        // end-of-test drain
        for (int k = 0; k < 5; k++) send(2'(k % 4));
        in_valid = 1'b0;
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 0);
        tick();
        chk("drain_valid", 32'(out_valid), 1);
        chk("drain_count", 32'(dct_count), 5);
        chk("drain_buffer", 32'(dct_buffer), 32'h0E4);
        tick();
        chk("drain_wait_ending", 32'(test_ending), 0);
        tick();
        chk("ending_pulse", 32'({test_ending, test_has_ended}), 32'b10);
        tick();
        chk("ended_flags", 32'({test_ending, test_has_ended}), 32'b01);
        chk("ended_in_ready", 32'(in_ready), 0);
        end_req = 1'b1; in_valid = 1'b1;
        tick(); tick();
        end_req = 1'b0; in_valid = 1'b0;
        chk("ended_sticky", 32'({test_ending, test_has_ended, in_ready}), 32'b010);

        // reset mid-frame
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        for (int k = 0; k < 7; k++) send(2'd1);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_outs", 32'({in_ready, out_valid, dct_count, test_has_ended}), 0);
        reset_n = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("midrst_no_frame", 32'(out_valid), 0);

        // reset while a frame is presented
        out_ready = 1'b0;
        for (int k = 0; k < 15; k++) send(2'd3);
        in_valid = 1'b0;
        chk("prst_valid", 32'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("vrst_valid", 32'(out_valid), 0);
        chk("vrst_data", 32'({dct_buffer, dct_count}), 0);
        reset_n = 1'b1;
        tick(); tick();
        chk("vrst_no_frame", 32'(out_valid), 0);

        // random traffic against a queue scoreboard
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 20000 && sent < 2000; cyc++) begin
                in_valid  = ($urandom_range(3) != 0);
                in_code   = 2'($urandom_range(3));
                out_ready = ($urandom_range(2) != 0);
                flush     = ($urandom_range(15) == 0);
                #1;
                if (in_valid && in_ready) begin
                    q.push_back(in_code);
                    sent++;
                end
                if (out_valid && out_ready) check_frame();
                tick();
            end
            chk("rnd_all_sent", 32'(sent), 2000);
            in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
            for (int cyc = 0; cyc < 40; cyc++) begin
                #1;
                if (out_valid && out_ready) check_frame();
                tick();
                flush = 1'b0;
            end
            chk("rnd_queue_empty", 32'(q.size()), 0);
            chk("rnd_out_idle", 32'(out_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
